// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the RAM arbiter.
// One instance per requester: request, grant and read return.
interface ram_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 6
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for a single-port RAM,
// with a one-cycle access stage and a whole-RAM fill engine.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    ram_arbiter_if.slave          port0,
    ram_arbiter_if.slave          port1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_read,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_FILL   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_prio;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_fill_val;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_done;
    logic [1:0]            r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic w_gnt_en;
    logic w_gnt0;
    logic w_gnt1;
    logic w_acc;
    logic w_fill_trig;
    logic w_last;

    // Grant decode: tie goes to r_prio; blocked while a fill is pending or running
    always_comb begin
        w_gnt_en    = rst_n && (r_state != S_FILL) && !r_pend;
        w_gnt0      = w_gnt_en && port0.req && (!port1.req || !r_prio);
        w_gnt1      = w_gnt_en && port1.req && (!port0.req || r_prio);
        w_acc       = w_gnt0 || w_gnt1;
        w_fill_trig = fill_start && (r_state != S_FILL) && !r_pend;
        w_last      = (r_cnt == '1);
    end

    assign port0.gnt    = w_gnt0;
    assign port1.gnt    = w_gnt1;
    assign port0.rvalid = r_rvalid[0];
    assign port1.rvalid = r_rvalid[1];
    assign port0.rdata  = r_rdata0;
    assign port1.rdata  = r_rdata1;
    assign fill_busy    = r_pend || (r_state == S_FILL);
    assign fill_done    = r_done;

    // Next state and RAM port drive
    always_comb begin
        w_state_nxt = r_state;
        ram_addr    = '0;
        ram_write   = 1'b0;
        ram_read    = 1'b0;
        ram_data_in = '0;
        unique case (r_state)
            S_IDLE, S_ACCESS: begin
                if (r_state == S_ACCESS) begin
                    ram_addr = r_addr;
                    if (r_we) begin
                        ram_write   = 1'b1;
                        ram_data_in = r_wdata;
                    end else begin
                        ram_read = 1'b1;
                    end
                end
                if (w_acc) begin
                    w_state_nxt = S_ACCESS;
                end else if (r_pend || w_fill_trig) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FILL: begin
                ram_write   = 1'b1;
                ram_addr    = r_cnt;
                ram_data_in = r_fill_val;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture accepted request into the stage and rotate priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_acc) begin
            r_owner <= w_gnt1;
            r_prio  <= w_gnt0;
            if (w_gnt1) begin
                r_we    <= port1.we;
                r_addr  <= port1.addr;
                r_wdata <= port1.wdata;
            end else begin
                r_we    <= port0.we;
                r_addr  <= port0.addr;
                r_wdata <= port0.wdata;
            end
        end
    end

    // Fill pending flag, latched fill word, address counter, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_fill_val <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_fill_trig) begin
                r_fill_val <= fill_value;
            end
            if (w_state_nxt == S_FILL) begin
                r_pend <= 1'b0;
            end else if (w_fill_trig) begin
                r_pend <= 1'b1;
            end
            r_cnt  <= (r_state == S_FILL) ? r_cnt + 1'b1 : '0;
            r_done <= (r_state == S_FILL) && w_last;
        end
    end

    // Read return: capture RAM data at the end of a read ACCESS cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_rvalid <= '0;
            if (r_state == S_ACCESS && !r_we) begin
                r_rvalid[r_owner] <= 1'b1;
                if (r_owner) begin
                    r_rdata1 <= ram_data_out;
                end else begin
                    r_rdata0 <= ram_data_out;
                end
            end
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the single-port `ram` block. It time-shares the RAM's single `addr`/`write`/`read` port between requester 0 and requester 1. It registers each accepted access into a one-cycle RAM access stage and returns read data with a valid strobe. It also contains a fill engine that overwrites the entire RAM with a constant, blocking both requesters while it runs.

## Interface
- `ADDR_WIDTH`, 9, RAM address width; the RAM depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 6, RAM word width.

Clock, reset and fill control:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fill_start`  in  1  one-cycle request to start a full-RAM fill.
- `fill_value`  in  DATA_WIDTH  fill word, sampled when the fill is started.
- `fill_busy`  out  1  high while a fill is pending or running.
- `fill_done`  out  1  one-cycle pulse after the last fill write.

Requester ports (x = 0, 1):
- `req_x`  in  1  access request.
- `we_x`  in  1  1 = write, 0 = read.
- `addr_x`  in  ADDR_WIDTH  access address.
- `wdata_x`  in  DATA_WIDTH  write data.
- `gnt_x`  out  1  combinational grant; the request is accepted at an edge where `req_x & gnt_x` is high.
- `rvalid_x`  out  1  one-cycle read-data strobe.
- `rdata_x`  out  DATA_WIDTH  read data; holds its value until the next read by this requester.

RAM side:
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_write`  out  1  RAM write enable.
- `ram_data_in`  out  DATA_WIDTH  RAM write data.
- `ram_read`  out  1  RAM read enable.
- `ram_data_out`  in  DATA_WIDTH  RAM read data; high-Z whenever `ram_read` = 0.

## Operation
- **States:** IDLE, ACCESS, FILL. The access stage is a single register set holding `owner`, `we`, `addr` and `wdata`.
- **Priority pointer:** `prio` is the requester that wins a tie. Reset value is 0.
- **Grants:** granting is enabled in IDLE and ACCESS, provided no fill is pending.
  - If only one requester asserts `req`, that requester is granted.
  - If both assert `req`, `gnt_prio` is granted.
  - After every accepted request, `prio` becomes the other requester.
- **Acceptance:** an accepted request is captured into the stage and the next state is ACCESS. If nothing is accepted, the next state is IDLE (or FILL, see below).
- **ACCESS cycle:**
  - `ram_addr` = stage `addr`.
  - For a write: `ram_write` = 1 and `ram_data_in` = stage `wdata`; the write commits at the closing edge.
  - For a read: `ram_read` = 1; `ram_data_out` is captured into `rdata_owner` at the closing edge, and `rvalid_owner` = 1 for the following cycle.
- **Back-to-back:** a new request may be accepted during ACCESS, so sustained throughput is one access per cycle.
- **Fill trigger:** `fill_start` sampled high in IDLE or ACCESS sets fill-pending.
  - `fill_busy` goes high in the next cycle.
  - `fill_value` is latched at the same edge.
  - Grants are suppressed from that next cycle onward; an access already in the stage completes normally.
  - The next state after the stage drains is FILL.
- **FILL:**
  - The counter starts at 0.
  - Each cycle drives `ram_write` = 1, `ram_addr` = counter and `ram_data_in` = the latched value, then increments the counter.
  - After address 2^ADDR_WIDTH−1 is written, the next state is IDLE, `fill_busy` = 0 and `fill_done` = 1 for one cycle.
  - `fill_start` during FILL is ignored.
- **Idle RAM drive:** when no access or fill is active, `ram_write` = `ram_read` = 0 and `ram_addr` = `ram_data_in` = 0.
- **Exclusivity:** `ram_write` and `ram_read` are never high together.

## Timing
- **Reset:** state = IDLE, `prio` = 0, stage cleared, counter = 0. All outputs are 0: `gnt`, `rvalid`, `rdata`, the `ram_*` outputs, `fill_busy` and `fill_done`.
- **Reset mid-operation:** `rst_n` low clears everything immediately. An in-flight access or fill is abandoned, so the write for the cycle in which reset is asserted is not issued. The fill does not resume after reset.
- **Read latency:** request accepted at edge E0 → ACCESS cycle → `rvalid` high in the cycle after edge E1, i.e. 2 cycles after acceptance.
- **Write visibility:** the write commits at E1. A read of the same address accepted at E1 returns the new data.
- **Requester hold rule:** requesters hold `req`, `we`, `addr` and `wdata` stable until the accepting edge. The request may change in the cycle after acceptance.
- **Fill duration:** exactly 2^ADDR_WIDTH FILL cycles. `fill_done` is asserted in the cycle after the last write.

## Test plan
- **Reset values:** hold reset, then release → every output is 0. Read addresses 0..3 via requester 0 → data matches `ram1.hex`.
- **Single requester:** requester 0 writes 0x2A to address 5, then reads address 5 → `rvalid_0` pulses 2 cycles after read acceptance with `rdata_0` = 0x2A. `gnt_0` is continuously high.
- **Contention:** both requesters hold reads for 4 cycles → grants alternate 0,1,0,1. Each `rvalid` returns the data of its own address.
- **Same-address ordering:** requester 1 writes 0x11 to address 0x1FF, and requester 0's read of 0x1FF is accepted on the next cycle → `rdata_0` = 0x11.
- **Fill during traffic:** pulse `fill_start` with `fill_value` = 0x3F during an ACCESS → the in-flight access completes, grants drop, `fill_busy` = 1, `fill_done` pulses after 512 writes. Random reads afterward return 0x3F.
- **Reset during fill:** assert `rst_n` low at fill address 100 → outputs are immediately 0, addresses ≥100 are unchanged, and state is IDLE after release.
